cla_seq_adder: RTL and testbench

- Multi-cycle sequencer for wide integer add using a single 8-bit carry-lookahead adder slice.
- Processes one byte per cycle, LSB byte first; the carry is registered between cycles.
- Sits between an operand producer and a result consumer, with valid/ready on both sides.
- Trades latency (NBYTES cycles) for area in the ALU datapath.

---
 rtl/cla_seq_pkg.sv | 17 +
 rtl/cla8b.sv | 39 +++
 rtl/cla_seq_adder.sv | 131 +++++++++++++
 tb/tb_cla_seq_adder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the byte-serial carry-lookahead adder.
package cla_seq_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte index width; a single-byte adder still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned nbytes);
    return (nbytes <= 1) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/cla8b.sv
// 8-bit carry-lookahead adder slice, purely combinational.
module cla8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flattened lookahead sum of products, not a ripple from c[i].
  always_comb begin
    logic term;
    logic prod;
    c    = '0;
    term = 1'b0;
    prod = 1'b1;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      term = 1'b0;
      prod = 1'b1;
      for (int j = i; j >= 0; j--) begin
        term = term | (g[j] & prod);
        prod = prod & p[j];
      end
      c[i+1] = term | (prod & cin);
    end
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];

endmodule

// File: rtl/cla_seq_adder.sv
// Wide adder sequenced one byte per cycle through a single cla8b slice, LSB byte first.
// Optional subtract mode (op_sub port) is enabled by defining CLA_SEQ_ADDER_SUB_EN.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  op_cin,
`ifdef CLA_SEQ_ADDER_SUB_EN
  input  logic                  op_sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  ovf,
  output logic                  busy
);

  localparam int unsigned W        = BYTE_W * NBYTES;
  localparam int unsigned IW       = idx_width(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  state_t            state_q, state_d;
  logic [W-1:0]      a_q, b_q, result_q;
  logic [IW-1:0]     idx_q;
  logic              carry_q, cout_q, ovf_q;
  logic [BYTE_W-1:0] a_byte, b_byte, slice_sum;
  logic              slice_cout, last;

`ifdef CLA_SEQ_ADDER_SUB_EN
  logic sub_q;
`endif

  assign last   = (idx_q == LAST_IDX);
  assign a_byte = a_q[BYTE_W*int'(idx_q) +: BYTE_W];
`ifdef CLA_SEQ_ADDER_SUB_EN
  // Subtract as A + ~B + 1; the +1 comes from the carry loaded at accept.
  assign b_byte = b_q[BYTE_W*int'(idx_q) +: BYTE_W] ^ {BYTE_W{sub_q}};
`else
  assign b_byte = b_q[BYTE_W*int'(idx_q) +: BYTE_W];
`endif

  cla8b u_slice (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept in IDLE, walk bytes in RUN, hold in DONE until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state only.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Operand capture and per-byte datapath; unwritten result bytes keep old values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef CLA_SEQ_ADDER_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= op_a;
            b_q   <= op_b;
            idx_q <= '0;
`ifdef CLA_SEQ_ADDER_SUB_EN
            sub_q   <= op_sub;
            carry_q <= op_sub | op_cin;
`else
            carry_q <= op_cin;
`endif
          end
        end
        RUN: begin
          result_q[BYTE_W*int'(idx_q) +: BYTE_W] <= slice_sum;
          carry_q <= slice_cout;
          if (last) begin
            cout_q <= slice_cout;
            ovf_q  <= (a_byte[BYTE_W-1] == b_byte[BYTE_W-1]) &
                      (slice_sum[BYTE_W-1] != a_byte[BYTE_W-1]);
            idx_q  <= '0;
          end else begin
            idx_q  <= idx_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder with a result scoreboard.
module tb_cla_seq_adder;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a, op_b;
  logic         op_cin;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout, ovf, busy;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
`ifdef CLA_SEQ_ADDER_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sub);
    exp_t         e;
    logic [W:0]   s;
    logic [W-1:0] bb;
    logic         c;
    bb = b;
    c  = ci;
`ifdef CLA_SEQ_ADDER_SUB_EN
    if (sub) begin
      bb = ~b;
      c  = 1'b1;
    end
`endif
    s    = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    e.res = s[W-1:0];
    e.co  = s[W];
    e.ov  = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    return e;
  endfunction

  // Present one operand set, wait for acceptance, push the expected result.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic sub);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_send", in_ready, 1);
    op_a     = a;
    op_b     = b;
    op_cin   = ci;
    op_sub   = sub;
    in_valid = 1'b1;
    sb.push_back(model(a, b, ci, sub));
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs to show the captured operands are what get used.
    op_a   = $urandom;
    op_b   = $urandom;
    op_cin = ~ci;
    op_sub = ~sub;
  endtask

  // Wait for out_valid, check latency and result, optionally stall, then consume.
  task automatic receive(input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, NBYTES);
    check("sb_nonempty", (sb.size() > 0), 1);
    e = sb.pop_front();
    check("result", result, e.res);
    check("cout", cout, e.co);
    check("ovf", ovf, e.ov);
    check("busy_done", busy, 1);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      op_a     = $urandom;
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_result", result, e.res);
      check("hold_cout", cout, e.co);
      check("hold_ovf", ovf, e.ov);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_cin    = 1'b0;
    op_sub    = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Byte carry into byte 1.
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    receive(0);
    // Carry ripples through every byte into cout.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    receive(0);
    // Signed overflow from carry-in.
    send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    receive(0);
    // Backpressure for 5 cycles, then immediate next op.
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    receive(5);
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    receive(0);

    // Reset during the second RUN cycle aborts the op.
    send(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    check("abort_busy", busy, 0);
    check("abort_cout", cout, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    send(32'hCAFE_0001, 32'h3501_FFFF, 1'b0, 1'b0);
    receive(0);

`ifdef CLA_SEQ_ADDER_SUB_EN
    send(32'd5, 32'd7, 1'b0, 1'b1);
    receive(0);
    send(32'h8000_0000, 32'd1, 1'b0, 1'b1);
    receive(0);
`endif

    for (int k = 0; k < 4; k++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      receive(k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
